lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit that initiates all accesses to the 32x32-bit word data memory in the 3-stage core.
- The memory offers only whole-word synchronous write and combinational read.
- This block adds byte/halfword loads and stores, sign/zero extension and misaligned access splitting, using read-modify-write sequencing.
- Sits between the execute stage (req/resp handshake) and the data memory port.

Parameters:
- WORDS, 32: memory depth in words. Must be a power of 2.
- IDXW, 5: word index width, log2(WORDS).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  illegal funct3
- mem_rd_addr  output  IDXW  memory read index
- mem_rd_data  input  32  memory read data (combinational)
- mem_wr_addr  output  IDXW  memory write index
- mem_wr_data  output  32  memory write data
- mem_we  output  1  memory write enable

Behaviour:
- Reset: state=IDLE, req_ready=0 while rst=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_rd_addr=0, mem_wr_addr=0, internal buffers cleared.
- Reset mid-operation aborts the access. A split store that already completed WR0 leaves the low word written; no further write occurs.
- FSM states: IDLE, RD0, RD1, WR0, WR1, DONE.
- req_ready=1 only in IDLE.
- Accept: req_valid && req_ready at a clock edge latches store, funct3, addr, wdata.
- Derived fields: off=addr[1:0], lo=addr[IDXW+1:2], hi=(lo+1) mod WORDS (wraps 31 -> 0). Address bits above IDXW+1 are ignored.
- split=1 when H/HU with off=3, or W with off!=0.
- Illegal request: funct3 in {011,110,111}, or store with funct3[2]=1. Transition IDLE -> DONE, resp_err=1, rdata=0, no memory write.
- IDLE -> WR0 for an aligned SW (no read needed). Otherwise IDLE -> RD0.
- RD0: mem_rd_addr=lo, buf0<=mem_rd_data. Next: RD1 if split; else WR0 for store, DONE for load.
- RD1: mem_rd_addr=hi, buf1<=mem_rd_data. Next: WR0 for store, DONE for load.
- Store merge:
  - 64-bit image {buf1,buf0}.
  - Mask (0xFF / 0xFFFF / 0xFFFFFFFF) shifted left by 8*off.
  - Data shifted left by 8*off.
  - Merged = (image & ~mask) | (data & mask).
- WR0: mem_we=1, mem_wr_addr=lo, mem_wr_data=merged[31:0]. Next: WR1 if split, else DONE.
- WR1: mem_we=1, mem_wr_addr=hi, mem_wr_data=merged[63:32]. Next: DONE.
- mem_we=0 in every other state.
- Load extract: x={buf1,buf0}>>(8*off). Result is the low byte/half, sign-extended for B/H and zero-extended for BU/HU; W returns x[31:0].
- Result is registered into resp_rdata on entry to DONE.
- DONE: resp_valid=1; outputs held stable until resp_ready=1, then -> IDLE.
- No new request is accepted in the DONE cycle.
- Latency from accept edge to first resp_valid cycle:
  - aligned load: 2 cycles
  - split load: 3 cycles
  - aligned SW: 2 cycles
  - sub-word or aligned-half/byte store: 3 cycles
  - split store: 5 cycles
  - illegal: 1 cycle
- Simultaneous rst and req_valid: reset wins, request dropped.

Test Plan:
- Reset, then observe -> req_ready=1, resp_valid=0, mem_we=0. Assert rst during RD1 of a split load -> next cycle IDLE, resp_valid=0.
- Preload word 2=0x8899AABB. LB addr 0x0A -> resp_rdata=0xFFFFFF99, 2 cycles after accept. LBU same address -> 0x00000099.
- Word 4=0x11223344. SH addr 0x11, data 0xBEEF -> mem write word 4=0x11BEEF44. One mem_we pulse, resp_valid 3 cycles after accept.
- Word 31=0xDDCCBBAA, word 0=0x44332211. LW addr 0x7E -> 0x2211DDCC. Reads hit index 31 then 0 (wraparound).
- SW addr 0x7D, data 0xA1B2C3D4 -> word 31=0xB2C3D4AA, word 0=0x443322A1. Two mem_we pulses, response 5 cycles after accept.
- funct3=011 load -> resp_err=1 next cycle, no mem_we. Hold resp_ready=0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit in front of a word-only data memory. Byte and halfword
// accesses, sign/zero extension and misaligned splitting are built from whole
// word reads and writes using read-modify-write sequencing.
module lsu_mem_port #(
    parameter int unsigned WORDS = 32,
    parameter int unsigned IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [IDXW-1:0] mem_rd_addr,
    input  logic [31:0]     mem_rd_data,
    output logic [IDXW-1:0] mem_wr_addr,
    output logic [31:0]     mem_wr_data,
    output logic            mem_we
);

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StWr0,
        StWr1,
        StDone
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [IDXW-1:0] r_lo;
    logic [31:0]     r_wdata;
    logic [31:0]     r_buf0;
    logic [31:0]     r_buf1;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [IDXW-1:0] w_hi;
    logic            w_split;
    logic            w_req_illegal;
    logic            w_req_aligned_sw;
    logic [4:0]      w_shamt;
    logic [31:0]     w_size_mask;
    logic [63:0]     w_mask64;
    logic [63:0]     w_data64;
    logic [63:0]     w_merged;
    logic [63:0]     w_ld_img;
    logic [63:0]     w_ld_shift;
    logic [31:0]     w_ld_data;
    logic            w_enter_done;
    logic [IDXW-1:0] w_rd_addr;
    logic [IDXW-1:0] w_wr_addr;
    logic [31:0]     w_wr_data;
    logic            w_we;
    logic            w_unused_addr;

    // Address bits above the word index do not select anything.
    assign w_unused_addr = ^{req_addr[31:IDXW+2]};

    // Request decode and derived address fields.
    always_comb begin
        w_req_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                           (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        w_req_aligned_sw = req_store && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);
        w_hi             = IDXW'((32'(r_lo) + 32'd1) % WORDS);
        w_split          = ((r_funct3[1:0] == 2'b01) && (r_off == 2'b11)) ||
                           ((r_funct3[1:0] == 2'b10) && (r_off != 2'b00));
        w_shamt          = {r_off, 3'b000};
    end

    // Store merge over the two-word image and load extraction.
    always_comb begin
        unique case (r_funct3[1:0])
            2'b00:   w_size_mask = 32'h0000_00FF;
            2'b01:   w_size_mask = 32'h0000_FFFF;
            default: w_size_mask = 32'hFFFF_FFFF;
        endcase
        w_mask64 = {32'b0, w_size_mask} << w_shamt;
        w_data64 = {32'b0, r_wdata} << w_shamt;
        w_merged = ({r_buf1, r_buf0} & ~w_mask64) | (w_data64 & w_mask64);

        // The word being read this cycle is not yet in its buffer.
        w_ld_img   = (r_state == StRd1) ? {mem_rd_data, r_buf0} : {r_buf1, mem_rd_data};
        w_ld_shift = w_ld_img >> w_shamt;
        unique case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_data = {24'b0, w_ld_shift[7:0]};
            3'b101:  w_ld_data = {16'b0, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift[31:0];
        endcase
    end

    // Next-state logic and memory port drive.
    always_comb begin
        w_state_d = r_state;
        w_rd_addr = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        w_we      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (w_req_illegal) begin
                        w_state_d = StDone;
                    end else if (w_req_aligned_sw) begin
                        w_state_d = StWr0;
                    end else begin
                        w_state_d = StRd0;
                    end
                end
            end
            StRd0: begin
                w_rd_addr = r_lo;
                if (w_split) begin
                    w_state_d = StRd1;
                end else begin
                    w_state_d = r_store ? StWr0 : StDone;
                end
            end
            StRd1: begin
                w_rd_addr = w_hi;
                w_state_d = r_store ? StWr0 : StDone;
            end
            StWr0: begin
                w_we      = 1'b1;
                w_wr_addr = r_lo;
                w_wr_data = w_merged[31:0];
                w_state_d = w_split ? StWr1 : StDone;
            end
            StWr1: begin
                w_we      = 1'b1;
                w_wr_addr = w_hi;
                w_wr_data = w_merged[63:32];
                w_state_d = StDone;
            end
            StDone: begin
                if (resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_enter_done = (w_state_d == StDone) && (r_state != StDone);
    end

    // State, request capture, read buffers and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
            r_lo     <= '0;
            r_wdata  <= '0;
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && req_valid) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                r_lo     <= req_addr[IDXW+1:2];
                r_wdata  <= req_wdata;
            end
            if (r_state == StRd0) begin
                r_buf0 <= mem_rd_data;
            end
            if (r_state == StRd1) begin
                r_buf1 <= mem_rd_data;
            end
            if (w_enter_done) begin
                // Only an illegal request goes straight from idle to done.
                r_err   <= (r_state == StIdle);
                r_rdata <= ((r_state == StRd0 || r_state == StRd1) && !r_store) ?
                           w_ld_data : 32'h0;
            end
        end
    end

    // Outputs are forced quiet while reset is held so nothing leaks mid-abort.
    always_comb begin
        req_ready   = (r_state == StIdle) && !rst;
        resp_valid  = (r_state == StDone) && !rst;
        resp_rdata  = r_rdata;
        resp_err    = r_err;
        mem_we      = w_we && !rst;
        mem_rd_addr = rst ? '0 : w_rd_addr;
        mem_wr_addr = rst ? '0 : w_wr_addr;
        mem_wr_data = w_wr_data;
    end

endmodule
